tkx_ctrl_32b: RTL

- Sequencing controller for the 32-bit-sliced 128-bit tweakey update chain (four chained key-register slices).
- Accepts a 4-beat serial key load over a valid/ready handshake, then runs ROUNDS forward tweakey-schedule updates.
- Optionally follows with ROUNDS reverse updates that restore the loaded key.
- Drives the chain's shift-enable, direction and update-enable strobes plus the round index for round-constant selection.

---
 rtl/tkx_ctrl_pkg.sv | 15 +
 rtl/tkx_round_cnt.sv | 38 +++
 rtl/tkx_ctrl_32b.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tkx_ctrl_pkg.sv
// rtl/tkx_ctrl_pkg.sv - shared types and constants for the tweakey chain controller
package tkx_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, KEYED, FWD, REV} state_e;

  localparam int SKINNY_ROUNDS = 56;
  localparam int KEY_BEATS     = 4;

  // dir=1: counting up, last round is rounds-1; dir=0: counting down, last round is 0
  function automatic logic round_last(input int round, input logic dir,
                                      input int rounds = SKINNY_ROUNDS);
    return dir ? (round == rounds - 1) : (round == 0);
  endfunction

endpackage

// File: rtl/tkx_round_cnt.sv
// rtl/tkx_round_cnt.sv - loadable up/down round counter with direction-aware terminal flag
module tkx_round_cnt import tkx_ctrl_pkg::*; #(
  parameter int RW     = 6,
  parameter int ROUNDS = SKINNY_ROUNDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [RW-1:0] load_val,
  input  logic          up,
  input  logic          en,
  output logic [RW-1:0] count,
  output logic          term
);

  logic [RW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = up ? count_q + RW'(1) : count_q - RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign term  = round_last(int'(count_q), up, ROUNDS);

endmodule

// File: rtl/tkx_ctrl_32b.sv
// rtl/tkx_ctrl_32b.sv - load/forward/revert sequencer for the 32-bit-sliced 128-bit tweakey chain
module tkx_ctrl_32b import tkx_ctrl_pkg::*; #(
  parameter int ROUNDS = SKINNY_ROUNDS,
  parameter int BEATS  = KEY_BEATS,
  parameter int RW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic          start,
  input  logic          auto_revert,
  input  logic          rev_only,
  output logic          tk_en,
  output logic          tk_se,
  output logic          tk_enc,
  output logic [RW-1:0] round,
  output logic          busy,
  output logic          done,
  output logic          key_valid
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            auto_q, auto_d;
  logic            done_q, done_d;
  logic            cnt_load, cnt_up, cnt_en, cnt_term;
  logic [RW-1:0]   cnt_val;
  logic            accept;

  assign accept = (state_q == IDLE) && load_valid && !clear;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    auto_d   = auto_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (clear) begin
      state_d  = IDLE;
      beat_d   = '0;
      cnt_load = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            if (beat_q == BW'(BEATS - 1)) begin
              state_d = KEYED;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + BW'(1);
            end
          end
        end
        KEYED: begin
          if (start) begin
            auto_d   = auto_revert;
            cnt_load = 1'b1;
            if (rev_only) begin
              state_d = REV;
              cnt_val = RW'(ROUNDS - 1);
            end else begin
              state_d = FWD;
            end
          end
        end
        FWD: begin
          // Handing over to REV keeps round at ROUNDS-1, the first revert round
          if (cnt_term) begin
            if (auto_q) begin
              state_d = REV;
            end else begin
              state_d = KEYED;
              done_d  = 1'b1;
            end
          end
        end
        REV: begin
          if (cnt_term) begin
            state_d = KEYED;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      auto_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q == FWD) || (state_q == REV);
  assign cnt_up = (state_q == FWD);
  assign cnt_en = busy && !cnt_term && !clear;

  tkx_round_cnt #(
    .RW     (RW),
    .ROUNDS (ROUNDS)
  ) u_round_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .up       (cnt_up),
    .en       (cnt_en),
    .count    (round),
    .term     (cnt_term)
  );

  assign load_ready = (state_q == IDLE);
  assign key_valid  = (state_q == KEYED);
  assign tk_se      = accept;
  assign tk_en      = accept || (busy && !clear);
  assign tk_enc     = (state_q == FWD);
  assign done       = done_q;

endmodule
